// File: rtl/sd_bus_pkg.sv
// Shared register map, interrupt bit positions and sequencer state type
// for the SD host bus controller.
package sd_bus_pkg;

    localparam int unsigned REG_CLKDIV     = 0;
    localparam int unsigned REG_ARG        = 1;
    localparam int unsigned REG_CMD        = 2;
    localparam int unsigned REG_SETTING    = 3;
    localparam int unsigned REG_CTRL       = 4;
    localparam int unsigned REG_BLKSIZE    = 5;
    localparam int unsigned REG_BLKCNT     = 6;
    localparam int unsigned REG_TIMEOUT    = 7;
    localparam int unsigned REG_IRQ_STATUS = 8;
    localparam int unsigned REG_IRQ_MASK   = 9;
    localparam int unsigned REG_STATE      = 10;
    localparam int unsigned REG_RESP0      = 16;

    localparam int IRQ_CMD_DONE  = 0;
    localparam int IRQ_CMD_ERR   = 1;
    localparam int IRQ_DATA_DONE = 2;
    localparam int IRQ_DATA_ERR  = 3;
    localparam int IRQ_TIMEOUT   = 4;
    localparam int IRQ_ABORTED   = 5;
    localparam int IRQ_BUSY_ERR  = 6;
    localparam int IRQ_W         = 7;

    localparam logic [31:0] RD_DEFAULT = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        DATA  = 2'd2,
        ABORT = 2'd3
    } sd_seq_state_t;

endpackage

// File: rtl/sd_irq_regs.sv
// Write-one-to-clear interrupt status with mask and a registered interrupt line.
// Hardware sets take precedence over a software clear landing in the same cycle.
module sd_irq_regs
    import sd_bus_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IRQ_W-1:0] set_vec,
    input  logic [IRQ_W-1:0] clr_vec,
    input  logic             mask_we,
    input  logic [IRQ_W-1:0] mask_wdata,
    output logic [IRQ_W-1:0] status_o,
    output logic [IRQ_W-1:0] mask_o,
    output logic             irq_o
);

    logic [IRQ_W-1:0] status_q, status_d;
    logic [IRQ_W-1:0] mask_q, mask_d;
    logic             irq_q, irq_d;

    always_comb begin
        status_d = (status_q & ~clr_vec) | set_vec;
        mask_d   = mask_we ? mask_wdata : mask_q;
        irq_d    = |(status_q & mask_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= '0;
            mask_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            status_q <= status_d;
            mask_q   <= mask_d;
            irq_q    <= irq_d;
        end
    end

    assign status_o = status_q;
    assign mask_o   = mask_q;
    assign irq_o    = irq_q;

endmodule

// File: rtl/sd_bus_ctrl.sv
// SD host register file and transaction sequencer between the core bus and
// the command/data engines: start/abort control, multi-block data, watchdog.
module sd_bus_ctrl
    import sd_bus_pkg::*;
#(
    parameter int ADDR_W      = 5,
    parameter int RESP_WORDS  = 4,
    parameter int BLKSIZE_W   = 12,
    parameter int BLKCNT_W    = 16,
    parameter int DIV_W       = 8,
    parameter int TIMEOUT_RST = 15,
    parameter int ABORT_CYC   = 4
)(
    input  logic                    msoc_clk,
    input  logic                    rst,
    input  logic                    reg_we,
    input  logic                    reg_re,
    input  logic [ADDR_W-1:0]       reg_addr,
    input  logic [31:0]             reg_wdata,
    output logic [31:0]             reg_rdata,
    output logic                    reg_rvalid,
    output logic [DIV_W-1:0]        clk_div_o,
    output logic [31:0]             cmd_arg_o,
    output logic [5:0]              cmd_i_o,
    output logic [2:0]              cmd_setting_o,
    output logic [2:0]              data_start_o,
    output logic [BLKSIZE_W-1:0]    blksize_o,
    output logic [31:0]             timeout_o,
    output logic                    cmd_start_o,
    output logic                    data_next_o,
    output logic                    cmd_rst_o,
    output logic                    data_rst_o,
    input  logic                    cmd_finish_i,
    input  logic                    cmd_crc_ok_i,
    input  logic                    cmd_index_ok_i,
    input  logic [32*RESP_WORDS-1:0] response_i,
    input  logic                    data_finish_i,
    input  logic                    data_crc_ok_i,
    output logic                    irq_o
);

    localparam logic [7:0] ABORT_LAST = 8'(ABORT_CYC - 1);

    logic [DIV_W-1:0]         clk_div_q, clk_div_d;
    logic [31:0]              arg_q, arg_d;
    logic [5:0]               cmd_idx_q, cmd_idx_d;
    logic [2:0]               setting_q, setting_d;
    logic [2:0]               data_start_q, data_start_d;
    logic [BLKSIZE_W-1:0]     blksize_q, blksize_d;
    logic [BLKCNT_W-1:0]      blkcnt_q, blkcnt_d;
    logic [31:0]              timeout_q, timeout_d;
    logic [32*RESP_WORDS-1:0] resp_q, resp_d;

    sd_seq_state_t            state_q, state_d;
    logic [31:0]              wdog_q, wdog_d;
    logic [7:0]               abort_cnt_q, abort_cnt_d;
    logic [BLKCNT_W-1:0]      blocks_left_q, blocks_left_d;
    logic                     cmd_start_q, cmd_start_d;
    logic                     data_next_q, data_next_d;
    logic                     cmd_rst_q, cmd_rst_d;
    logic                     data_rst_q, data_rst_d;
    logic [31:0]              rdata_q, rdata_d;
    logic                     rvalid_q, rvalid_d;

    logic                     cfg_we;
    logic                     ctrl_we;
    logic                     sw_start;
    logic                     sw_abort;
    logic                     wdog_hit;
    logic [IRQ_W-1:0]         irq_set;
    logic [IRQ_W-1:0]         irq_clr;
    logic                     irq_mask_we;
    logic [IRQ_W-1:0]         irq_status;
    logic [IRQ_W-1:0]         irq_mask;
    logic [31:0]              state_word;
    logic [31:0]              rd_word;

    assign cfg_we      = reg_we && (state_q == IDLE);
    assign ctrl_we     = reg_we && (reg_addr == ADDR_W'(REG_CTRL));
    assign sw_start    = ctrl_we && reg_wdata[0];
    assign sw_abort    = ctrl_we && reg_wdata[1];
    assign wdog_hit    = (timeout_q != '0) && (wdog_q == timeout_q);
    assign irq_mask_we = reg_we && (reg_addr == ADDR_W'(REG_IRQ_MASK));
    assign irq_clr     = (reg_we && (reg_addr == ADDR_W'(REG_IRQ_STATUS))) ?
                         reg_wdata[IRQ_W-1:0] : '0;

    // Configuration registers only accept writes while the sequencer is idle.
    always_comb begin
        clk_div_d    = clk_div_q;
        arg_d        = arg_q;
        cmd_idx_d    = cmd_idx_q;
        setting_d    = setting_q;
        data_start_d = data_start_q;
        blksize_d    = blksize_q;
        blkcnt_d     = blkcnt_q;
        timeout_d    = timeout_q;
        if (cfg_we) begin
            if (reg_addr == ADDR_W'(REG_CLKDIV))  clk_div_d = reg_wdata[DIV_W-1:0];
            if (reg_addr == ADDR_W'(REG_ARG))     arg_d     = reg_wdata;
            if (reg_addr == ADDR_W'(REG_CMD))     cmd_idx_d = reg_wdata[5:0];
            if (reg_addr == ADDR_W'(REG_SETTING)) begin
                setting_d    = reg_wdata[2:0];
                data_start_d = reg_wdata[5:3];
            end
            if (reg_addr == ADDR_W'(REG_BLKSIZE)) blksize_d = reg_wdata[BLKSIZE_W-1:0];
            if (reg_addr == ADDR_W'(REG_BLKCNT))  blkcnt_d  = reg_wdata[BLKCNT_W-1:0];
            if (reg_addr == ADDR_W'(REG_TIMEOUT)) timeout_d = reg_wdata;
        end
    end

    // Sequencer next state; a finish pulse is handled before the watchdog.
    always_comb begin
        state_d       = state_q;
        wdog_d        = wdog_q;
        abort_cnt_d   = abort_cnt_q;
        blocks_left_d = blocks_left_q;
        resp_d        = resp_q;
        cmd_start_d   = 1'b0;
        data_next_d   = 1'b0;
        cmd_rst_d     = cmd_rst_q;
        data_rst_d    = data_rst_q;
        irq_set       = '0;

        case (state_q)
            IDLE: begin
                if (sw_start) begin
                    cmd_start_d   = 1'b1;
                    blocks_left_d = (blkcnt_q == '0) ? BLKCNT_W'(1) : blkcnt_q;
                    wdog_d        = '0;
                    state_d       = CMD;
                end
            end
            CMD: begin
                wdog_d = wdog_q + 32'd1;
                if (cmd_finish_i) begin
                    resp_d                = response_i;
                    irq_set[IRQ_CMD_DONE] = 1'b1;
                    if (!cmd_crc_ok_i || !cmd_index_ok_i) begin
                        irq_set[IRQ_CMD_ERR] = 1'b1;
                        state_d              = IDLE;
                    end else if (data_start_q != 3'd0) begin
                        wdog_d  = '0;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (wdog_hit) begin
                    irq_set[IRQ_TIMEOUT] = 1'b1;
                    abort_cnt_d          = '0;
                    cmd_rst_d            = 1'b1;
                    data_rst_d           = 1'b1;
                    state_d              = ABORT;
                end
            end
            DATA: begin
                wdog_d = wdog_q + 32'd1;
                if (data_finish_i) begin
                    blocks_left_d = blocks_left_q - BLKCNT_W'(1);
                    if (!data_crc_ok_i) begin
                        irq_set[IRQ_DATA_ERR] = 1'b1;
                        state_d               = IDLE;
                    end else if (blocks_left_q == BLKCNT_W'(1)) begin
                        irq_set[IRQ_DATA_DONE] = 1'b1;
                        state_d                = IDLE;
                    end else begin
                        data_next_d = 1'b1;
                        wdog_d      = '0;
                    end
                end else if (wdog_hit) begin
                    irq_set[IRQ_TIMEOUT] = 1'b1;
                    abort_cnt_d          = '0;
                    cmd_rst_d            = 1'b1;
                    data_rst_d           = 1'b1;
                    state_d              = ABORT;
                end
            end
            ABORT: begin
                if (abort_cnt_q == ABORT_LAST) begin
                    cmd_rst_d     = 1'b0;
                    data_rst_d    = 1'b0;
                    blocks_left_d = '0;
                    state_d       = IDLE;
                end else begin
                    abort_cnt_d = abort_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Software abort overrides everything, including a start in the same write.
        if (sw_abort) begin
            irq_set[IRQ_ABORTED] = 1'b1;
            abort_cnt_d          = '0;
            cmd_rst_d            = 1'b1;
            data_rst_d           = 1'b1;
            cmd_start_d          = 1'b0;
            data_next_d          = 1'b0;
            state_d              = ABORT;
        end else if (sw_start && (state_q != IDLE)) begin
            irq_set[IRQ_BUSY_ERR] = 1'b1;
        end
    end

    always_comb begin
        state_word                   = '0;
        state_word[BLKCNT_W+7:8]     = blocks_left_q;
        state_word[1:0]              = state_q;

        rd_word = RD_DEFAULT;
        if      (reg_addr == ADDR_W'(REG_CLKDIV))     rd_word = 32'(clk_div_q);
        else if (reg_addr == ADDR_W'(REG_ARG))        rd_word = arg_q;
        else if (reg_addr == ADDR_W'(REG_CMD))        rd_word = {26'd0, cmd_idx_q};
        else if (reg_addr == ADDR_W'(REG_SETTING))    rd_word = {26'd0, data_start_q, setting_q};
        else if (reg_addr == ADDR_W'(REG_CTRL))       rd_word = 32'd0;
        else if (reg_addr == ADDR_W'(REG_BLKSIZE))    rd_word = 32'(blksize_q);
        else if (reg_addr == ADDR_W'(REG_BLKCNT))     rd_word = 32'(blkcnt_q);
        else if (reg_addr == ADDR_W'(REG_TIMEOUT))    rd_word = timeout_q;
        else if (reg_addr == ADDR_W'(REG_IRQ_STATUS)) rd_word = 32'(irq_status);
        else if (reg_addr == ADDR_W'(REG_IRQ_MASK))   rd_word = 32'(irq_mask);
        else if (reg_addr == ADDR_W'(REG_STATE))      rd_word = state_word;
        for (int i = 0; i < RESP_WORDS; i++) begin
            if (reg_addr == ADDR_W'(REG_RESP0 + i)) rd_word = resp_q[i*32 +: 32];
        end

        rdata_d  = reg_re ? rd_word : 32'd0;
        rvalid_d = reg_re;
    end

    always_ff @(posedge msoc_clk) begin
        if (rst) begin
            clk_div_q     <= '0;
            arg_q         <= '0;
            cmd_idx_q     <= '0;
            setting_q     <= '0;
            data_start_q  <= '0;
            blksize_q     <= '0;
            blkcnt_q      <= '0;
            timeout_q     <= 32'(TIMEOUT_RST);
            resp_q        <= '0;
            state_q       <= IDLE;
            wdog_q        <= '0;
            abort_cnt_q   <= '0;
            blocks_left_q <= '0;
            cmd_start_q   <= 1'b0;
            data_next_q   <= 1'b0;
            cmd_rst_q     <= 1'b0;
            data_rst_q    <= 1'b0;
            rdata_q       <= '0;
            rvalid_q      <= 1'b0;
        end else begin
            clk_div_q     <= clk_div_d;
            arg_q         <= arg_d;
            cmd_idx_q     <= cmd_idx_d;
            setting_q     <= setting_d;
            data_start_q  <= data_start_d;
            blksize_q     <= blksize_d;
            blkcnt_q      <= blkcnt_d;
            timeout_q     <= timeout_d;
            resp_q        <= resp_d;
            state_q       <= state_d;
            wdog_q        <= wdog_d;
            abort_cnt_q   <= abort_cnt_d;
            blocks_left_q <= blocks_left_d;
            cmd_start_q   <= cmd_start_d;
            data_next_q   <= data_next_d;
            cmd_rst_q     <= cmd_rst_d;
            data_rst_q    <= data_rst_d;
            rdata_q       <= rdata_d;
            rvalid_q      <= rvalid_d;
        end
    end

    sd_irq_regs u_irq (
        .clk        (msoc_clk),
        .rst        (rst),
        .set_vec    (irq_set),
        .clr_vec    (irq_clr),
        .mask_we    (irq_mask_we),
        .mask_wdata (reg_wdata[IRQ_W-1:0]),
        .status_o   (irq_status),
        .mask_o     (irq_mask),
        .irq_o      (irq_o)
    );

    assign reg_rdata     = rdata_q;
    assign reg_rvalid    = rvalid_q;
    assign clk_div_o     = clk_div_q;
    assign cmd_arg_o     = arg_q;
    assign cmd_i_o       = cmd_idx_q;
    assign cmd_setting_o = setting_q;
    assign data_start_o  = data_start_q;
    assign blksize_o     = blksize_q;
    assign timeout_o     = timeout_q;
    assign cmd_start_o   = cmd_start_q;
    assign data_next_o   = data_next_q;
    assign cmd_rst_o     = cmd_rst_q;
    assign data_rst_o    = data_rst_q;

endmodule
